// File: rtl/apb_master.sv
// Single-outstanding APB requester: IDLE->SETUP->ACCESS->RESP with a watchdog on ACCESS.
// Response earliest two edges after acceptance; the response is held until consumed and no new request is taken meanwhile.
module apb_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       am_clk,
    input  logic       am_reset,
    input  logic       am_req_valid,
    output logic       am_req_ready,
    input  logic       am_req_write,
    input  logic [7:0] am_req_addr,
    input  logic [7:0] am_req_wdata,
    output logic       am_rsp_valid,
    input  logic       am_rsp_ready,
    output logic [7:0] am_rsp_rdata,
    output logic       am_rsp_err,
    output logic       am_rsp_timeout,
    output logic       am_psel,
    output logic       am_penable,
    output logic       am_pwrite,
    output logic [7:0] am_paddr,
    output logic [7:0] am_pwdata,
    input  logic       am_pready,
    input  logic       am_pslverr,
    input  logic [7:0] am_prdata
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    typedef struct packed {
        logic [7:0] rdata;
        logic       err;
        logic       timeout;
    } rsp_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] wd_cnt;
    logic       wd_expire;
    rsp_t       rsp_q;

    assign wd_expire = (wd_cnt == 8'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge am_clk) begin
        if (am_reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // pready is checked ahead of the watchdog so a completion on the threshold cycle wins
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (am_req_valid) state_nxt = SETUP;
            SETUP:   state_nxt = ACCESS;
            ACCESS:  if (am_pready || wd_expire) state_nxt = RESP;
            RESP:    if (am_rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        am_req_ready = 1'b0;
        am_psel      = 1'b0;
        am_penable   = 1'b0;
        am_rsp_valid = 1'b0;
        case (state)
            IDLE:    am_req_ready = 1'b1;
            SETUP:   am_psel      = 1'b1;
            ACCESS:  begin
                am_psel    = 1'b1;
                am_penable = 1'b1;
            end
            RESP:    am_rsp_valid = 1'b1;
            default: am_req_ready = 1'b0;
        endcase
    end

    always_ff @(posedge am_clk) begin
        if (am_reset) begin
            am_pwrite <= 1'b0;
            am_paddr  <= 8'h00;
            am_pwdata <= 8'h00;
            wd_cnt    <= 8'h00;
            rsp_q     <= '0;
        end else begin
            if (state == IDLE && am_req_valid) begin
                am_pwrite <= am_req_write;
                am_paddr  <= am_req_addr;
                am_pwdata <= am_req_wdata;
            end
            if (state == SETUP) begin
                wd_cnt <= 8'h00;
            end else if (state == ACCESS && !am_pready && !wd_expire) begin
                wd_cnt <= wd_cnt + 8'h01;
            end
            if (state == ACCESS && am_pready) begin
                rsp_q.rdata   <= (!am_pwrite && !am_pslverr) ? am_prdata : 8'h00;
                rsp_q.err     <= am_pslverr;
                rsp_q.timeout <= 1'b0;
            end else if (state == ACCESS && wd_expire) begin
                rsp_q <= '{rdata: 8'h00, err: 1'b1, timeout: 1'b1};
            end
        end
    end

    assign am_rsp_rdata   = rsp_q.rdata;
    assign am_rsp_err     = rsp_q.err;
    assign am_rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed scenarios plus randomized transfers against a transfer-level model.
module tb_apb_master;
    localparam int TO = 16;

    logic       am_clk = 1'b0;
    logic       am_reset = 1'b1;
    logic       am_req_valid = 1'b0;
    logic       am_req_ready;
    logic       am_req_write = 1'b0;
    logic [7:0] am_req_addr = 8'h00;
    logic [7:0] am_req_wdata = 8'h00;
    logic       am_rsp_valid;
    logic       am_rsp_ready = 1'b0;
    logic [7:0] am_rsp_rdata;
    logic       am_rsp_err;
    logic       am_rsp_timeout;
    logic       am_psel;
    logic       am_penable;
    logic       am_pwrite;
    logic [7:0] am_paddr;
    logic [7:0] am_pwdata;
    logic       am_pready = 1'b0;
    logic       am_pslverr = 1'b0;
    logic [7:0] am_prdata = 8'h00;

    int checks = 0;
    int failures = 0;

    apb_master #(.TIMEOUT_CYCLES(TO)) dut (
        .am_clk(am_clk), .am_reset(am_reset),
        .am_req_valid(am_req_valid), .am_req_ready(am_req_ready),
        .am_req_write(am_req_write), .am_req_addr(am_req_addr), .am_req_wdata(am_req_wdata),
        .am_rsp_valid(am_rsp_valid), .am_rsp_ready(am_rsp_ready),
        .am_rsp_rdata(am_rsp_rdata), .am_rsp_err(am_rsp_err), .am_rsp_timeout(am_rsp_timeout),
        .am_psel(am_psel), .am_penable(am_penable), .am_pwrite(am_pwrite),
        .am_paddr(am_paddr), .am_pwdata(am_pwdata),
        .am_pready(am_pready), .am_pslverr(am_pslverr), .am_prdata(am_prdata)
    );

    always #5 am_clk = ~am_clk;

    initial begin
        #500000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge am_clk);
        @(negedge am_clk);
    endtask

    // One transfer; the slave raises pready in ACCESS cycle waits+1, bp = cycles of response back-pressure.
    task automatic run_txn(input logic wr, input logic [7:0] addr, input logic [7:0] wdata,
                           input int waits, input logic slverr, input logic [7:0] prdata, input int bp);
        int psel_n = 0;
        int pen_n = 0;
        int cyc = 0;
        bit done = 0;
        bit tmo;
        int e_access;
        logic [7:0] e_rdata;
        logic e_err;
        tmo      = (waits >= TO);
        e_access = tmo ? TO : waits + 1;
        e_rdata  = (tmo || wr || slverr) ? 8'h00 : prdata;
        e_err    = tmo || slverr;

        check("req_ready_idle", {31'd0, am_req_ready}, 1);
        am_req_valid = 1'b1; am_req_write = wr; am_req_addr = addr; am_req_wdata = wdata;
        step();
        am_req_valid = 1'b0;
        am_req_write = 1'($urandom); am_req_addr = 8'($urandom); am_req_wdata = 8'($urandom);
        while (!done && cyc < 300) begin
            if (am_rsp_valid) begin
                done = 1;
            end else begin
                if (am_psel) begin
                    psel_n++;
                    check("paddr_stable", {24'd0, am_paddr}, {24'd0, addr});
                    check("pwdata_stable", {24'd0, am_pwdata}, {24'd0, wdata});
                    check("pwrite_stable", {31'd0, am_pwrite}, {31'd0, wr});
                end
                if (am_psel && am_penable) begin
                    pen_n++;
                    am_pready  = (pen_n == waits + 1);
                    am_pslverr = am_pready ? slverr : 1'($urandom);
                    am_prdata  = am_pready ? prdata : 8'($urandom);
                end else begin
                    am_pready  = 1'($urandom);
                    am_pslverr = 1'($urandom);
                    am_prdata  = 8'($urandom);
                end
                step();
                cyc++;
            end
        end
        am_pready = 1'b0; am_pslverr = 1'b0;
        check("rsp_valid_seen", {31'd0, done}, 1);
        check("psel_cycles", psel_n, e_access + 1);
        check("penable_cycles", pen_n, e_access);
        check("psel_in_resp", {31'd0, am_psel}, 0);

        am_req_valid = (bp > 0);
        for (int i = 0; i <= bp; i++) begin
            check("rsp_valid_hold", {31'd0, am_rsp_valid}, 1);
            check("rsp_rdata", {24'd0, am_rsp_rdata}, {24'd0, e_rdata});
            check("rsp_err", {31'd0, am_rsp_err}, {31'd0, e_err});
            check("rsp_timeout", {31'd0, am_rsp_timeout}, {31'd0, tmo});
            check("req_ready_in_resp", {31'd0, am_req_ready}, 0);
            am_rsp_ready = (i == bp);
            step();
        end
        am_rsp_ready = 1'b0;
        am_req_valid = 1'b0;
        check("rsp_valid_after_hs", {31'd0, am_rsp_valid}, 0);
        check("req_ready_after_hs", {31'd0, am_req_ready}, 1);
    endtask

    initial begin
        @(negedge am_clk);
        step();
        am_reset = 1'b0;
        step();
        check("rst_req_ready", {31'd0, am_req_ready}, 1);
        check("rst_psel", {31'd0, am_psel}, 0);
        check("rst_penable", {31'd0, am_penable}, 0);
        check("rst_rsp_valid", {31'd0, am_rsp_valid}, 0);
        check("rst_rsp_fields", {21'd0, am_rsp_rdata, am_rsp_err, am_rsp_timeout}, 0);
        check("rst_apb_regs", {15'd0, am_pwrite, am_paddr, am_pwdata}, 0);

        run_txn(1'b1, 8'h01, 8'hA5, 0, 1'b0, 8'h77, 0);
        run_txn(1'b0, 8'h00, 8'h00, 3, 1'b0, 8'h3C, 0);
        run_txn(1'b0, 8'h02, 8'h00, 0, 1'b1, 8'h99, 0);
        run_txn(1'b0, 8'h03, 8'h11, TO, 1'b0, 8'h55, 0);
        run_txn(1'b1, 8'h04, 8'h22, 200, 1'b1, 8'h55, 1);
        run_txn(1'b0, 8'h05, 8'h33, TO - 1, 1'b0, 8'hC3, 0);
        run_txn(1'b0, 8'h06, 8'h44, TO - 2, 1'b1, 8'hC3, 0);
        run_txn(1'b1, 8'h07, 8'h5A, 1, 1'b0, 8'h00, 5);
        run_txn(1'b0, 8'h08, 8'h00, 2, 1'b0, 8'hE1, 5);

        // reset while in ACCESS aborts the transfer
        am_req_valid = 1'b1; am_req_write = 1'b0; am_req_addr = 8'h09;
        step();
        am_req_valid = 1'b0;
        step();
        check("mid_access_penable", {31'd0, am_penable}, 1);
        step();
        am_reset = 1'b1;
        step();
        check("rst_mid_psel", {31'd0, am_psel}, 0);
        check("rst_mid_penable", {31'd0, am_penable}, 0);
        check("rst_mid_rsp_valid", {31'd0, am_rsp_valid}, 0);
        check("rst_mid_paddr", {24'd0, am_paddr}, 0);
        am_reset = 1'b0;
        step();
        check("rst_mid_req_ready", {31'd0, am_req_ready}, 1);
        am_pready = 1'b1;
        step();
        am_pready = 1'b0;
        check("rst_mid_no_rsp", {31'd0, am_rsp_valid}, 0);

        for (int n = 0; n < 25; n++) begin
            run_txn(1'($urandom), 8'($urandom), 8'($urandom), int'($urandom_range(0, TO + 4)),
                    1'($urandom), 8'($urandom), int'($urandom_range(0, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
